nonzero_scheduler: RTL and testbench
====================================

NONZERO_SCHEDULER -- requirements
Module: nonzero_scheduler

Interface
- REQ-001: Parameter NUM_ELEM, default 16: number of elements per input vector; power of 2, >= 2.
- REQ-002: Parameter DATA_WIDTH, default 16: bit width of each element.
- REQ-003: Derived IDX_W = ceil(log2(NUM_ELEM)), the width of out_index.
- REQ-004: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005: rst  input  1  synchronous, active-high reset.
- REQ-006: in_valid  input  1  upstream vector valid.
- REQ-007: in_ready  output  1  the block accepts a vector this cycle.
- REQ-008: in_data  input  NUM_ELEM*DATA_WIDTH  element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-009: out_valid  output  1  a nonzero element is presented.
- REQ-010: out_ready  input  1  downstream accepts the presented element.
- REQ-011: out_index  output  IDX_W  position of the presented element.
- REQ-012: out_data  output  DATA_WIDTH  value of the presented element.
- REQ-013: out_last  output  1  the presented element is the final nonzero element of the vector.
- REQ-014: done  output  1  one-cycle pulse marking the end of the vector.
- REQ-015: busy  output  1  high in every state other than IDLE.

Function
- REQ-016: The FSM SHALL have three states, IDLE, SCAN and DONE; reset state is IDLE.
- REQ-017: In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
- REQ-018: On in_valid & in_ready the block SHALL register in_data and a NUM_ELEM-bit mask (bit i = element i != 0), then move to SCAN.
- REQ-019: In SCAN with mask != 0, out_valid SHALL be 1.
- REQ-020: In SCAN, out_index SHALL be the lowest set bit of mask, found by a leading-nonzero detector on the mask, and out_data SHALL be the stored element at that index.
- REQ-021: out_last SHALL be 1 when out_valid = 1 and mask has exactly one bit set; otherwise 0.
- REQ-022: On out_valid & out_ready, the mask bit at out_index SHALL be cleared.
- REQ-023: While out_ready = 0, out_index, out_data and out_last SHALL stay stable.
- REQ-024: When the element with out_last = 1 is accepted, the FSM SHALL move to DONE.
- REQ-025: If SCAN is entered with mask == 0 (all-zero vector), out_valid SHALL stay 0 and the FSM SHALL move to DONE on the next edge.
- REQ-026: In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
- REQ-027: Latency: a vector accepted at edge T gives its first out_valid in the cycle after T; throughput is one element per cycle while out_ready = 1.
- REQ-028: Overhead between vectors SHALL be exactly 2 cycles (DONE, then IDLE accept) after the last element handshake.
- REQ-029: in_data SHALL be ignored outside the IDLE accept cycle; the stored vector SHALL NOT change during SCAN.
- REQ-030: out_valid, out_last and done SHALL be 0 outside SCAN/DONE as specified above.
- REQ-031: out_index and out_data SHALL be 0 when out_valid = 0.

Reset
- REQ-032: When rst = 1 at an edge, in any state including mid-SCAN, the block SHALL go to IDLE with mask and stored data cleared.
- REQ-033: After such a reset, out_valid, out_last, done and busy SHALL be 0, out_index and out_data SHALL be 0, and in_ready SHALL be 1 in the next cycle.
- REQ-034: Any partially drained vector SHALL be discarded on reset, with no done pulse.
- REQ-035: rst SHALL take priority over every simultaneous handshake.

Verification (NUM_ELEM=8, DATA_WIDTH=8)
- REQ-036: Stream, out_ready=1: vector elements {0,5,0,0,9,0,0,3} (index 0..7) -> (index 1, data 5), (4, 9), (7, 3) on 3 consecutive cycles; out_last only on index 7; done 1 cycle later.
- REQ-037: All-zero vector: all elements 0 -> no out_valid; done pulses in the second cycle after accept; in_ready returns the cycle after that.
- REQ-038: Backpressure: elements {7,7,7,7,7,7,7,7}, out_ready toggling 1,0,1,0... -> indices 0..7 in order, each held stable while stalled, 8 handshakes total.
- REQ-039: Single element: only element 7 = 0xFF -> one beat (index 7, data 0xFF) with out_last=1.
- REQ-040: Reset mid-SCAN: rst asserted after the 2nd handshake of the first scenario -> next cycle IDLE, in_ready=1, out_valid=0, no done.
- REQ-041: Back-to-back: in_valid held high with two vectors -> second accepted exactly 2 cycles after the first vector's last handshake; in_data changes during SCAN have no effect on the outputs.

Source files
------------

// File: rtl/nonzero_scheduler.sv
// Sparse-vector scheduler: captures one vector, then emits its nonzero elements in
// ascending index order with a valid/ready handshake, followed by a one-cycle done pulse.
module nonzero_scheduler #(
  parameter int unsigned NUM_ELEM   = 16,
  parameter int unsigned DATA_WIDTH = 16,
  localparam int unsigned IDX_W     = $clog2(NUM_ELEM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_ELEM*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_index,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_last,
  output logic                           done,
  output logic                           busy
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                          state_q, state_d;
  logic [NUM_ELEM-1:0]             mask_q, mask_d;
  logic [NUM_ELEM*DATA_WIDTH-1:0]  data_q, data_d;

  logic [NUM_ELEM-1:0]   in_mask;
  logic [IDX_W-1:0]      lsb_idx;
  logic                  single_bit;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    in_mask = '0;
    for (int i = 0; i < int'(NUM_ELEM); i++) begin
      in_mask[i] = |in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Descending scan so the lowest set bit is the last one to win.
  always_comb begin
    lsb_idx = '0;
    for (int i = int'(NUM_ELEM) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        lsb_idx = IDX_W'(i);
      end
    end
  end

  assign single_bit = (mask_q != '0) && ((mask_q & (mask_q - NUM_ELEM'(1))) == '0);
  assign sel_data   = data_q[lsb_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          mask_d  = in_mask;
          state_d = StScan;
        end
      end
      StScan: begin
        if (mask_q == '0) begin
          state_d = StDone;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            mask_d[lsb_idx] = 1'b0;
            if (single_bit) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_index = out_valid ? lsb_idx : '0;
  assign out_data  = out_valid ? sel_data : '0;
  assign out_last  = out_valid & single_bit;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_nonzero_scheduler.sv
// Randomized and directed bench for nonzero_scheduler (NUM_ELEM=8, DATA_WIDTH=8) against
// a queue-based reference model of the element stream.
module tb_nonzero_scheduler;

  localparam int unsigned NE = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [63:0]   in_data = '0;
  logic          in_ready, out_valid, out_last, done, busy;
  logic [2:0]    out_index;
  logic [7:0]    out_data;

  nonzero_scheduler #(
    .NUM_ELEM  (NE),
    .DATA_WIDTH(DW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting for a vector, 1 = emitting, 2 = end-of-vector cycle.
  typedef struct {
    int idx;
    int data;
  } beat_t;

  beat_t q[$];
  int    phase = 0;
  int    obs_hs = 0;

  task automatic step(input logic r, input logic v, input logic [63:0] d, input logic ordy);
    logic        e_valid;
    beat_t       b;
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    e_valid = (phase == 1) && (q.size() > 0);
    check_eq("in_ready", 32'(in_ready), 32'(phase == 0));
    check_eq("busy", 32'(busy), 32'(phase != 0));
    check_eq("done", 32'(done), 32'(phase == 2));
    check_eq("out_valid", 32'(out_valid), 32'(e_valid));
    check_eq("out_index", 32'(out_index), e_valid ? 32'(q[0].idx) : 32'd0);
    check_eq("out_data", 32'(out_data), e_valid ? 32'(q[0].data) : 32'd0);
    check_eq("out_last", 32'(out_last), 32'(e_valid && q.size() == 1));
    if (out_valid === 1'b1 && out_ready === 1'b1 && !r) obs_hs++;
    if (r) begin
      phase = 0;
      q.delete();
    end else begin
      case (phase)
        0: if (v) begin
          q.delete();
          for (int i = 0; i < 8; i++) begin
            if (d[i*8 +: 8] != 8'd0) begin
              b.idx  = i;
              b.data = int'(d[i*8 +: 8]);
              q.push_back(b);
            end
          end
          phase = 1;
        end
        1: if (q.size() == 0) begin
          phase = 2;
        end else if (ordy) begin
          void'(q.pop_front());
          if (q.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  endtask

  function automatic logic [63:0] rand_vec();
    logic [63:0] vec;
    int          mode;
    vec  = '0;
    mode = int'($urandom_range(0, 7));
    for (int i = 0; i < 8; i++) begin
      if (mode != 0 && $urandom_range(0, 1) == 1) vec[i*8 +: 8] = 8'($urandom_range(1, 255));
    end
    return vec;
  endfunction

  // Element 7 is the leftmost byte.
  localparam logic [63:0] VecA    = {8'd3, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd5, 8'd0};
  localparam logic [63:0] VecSev  = {8{8'd7}};
  localparam logic [63:0] VecLone = {8'hFF, 56'd0};

  initial begin
    int hs0;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    // Sparse stream with full throughput.
    step(1'b0, 1'b1, VecA, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 64'($urandom), 1'b1);

    // All-zero vector.
    step(1'b0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Backpressure with alternating ready.
    hs0 = obs_hs;
    step(1'b0, 1'b1, VecSev, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, VecA, (i % 2) == 0);
    check_eq("hs_count", 32'(obs_hs - hs0), 32'd8);

    // Single nonzero element at the top index.
    step(1'b0, 1'b1, VecLone, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Reset after the second handshake, colliding with the third one.
    step(1'b0, 1'b1, VecA, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Back-to-back vectors with in_valid held and in_data churning during the scan.
    step(1'b0, 1'b1, VecA, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rand_vec(), 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, rand_vec(),
           $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
